// File: rtl/mode_arbiter.sv
// Mode selector for the bike-fit board: synchronises and debounces the mode switches,
// commits the lowest-index request and routes that mode's LEDs/buzzer after an ADC settle window.
module mode_arbiter #(
    parameter int unsigned NUM_MODES       = 3,
    parameter int unsigned LED_WIDTH       = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SETTLE_CYCLES   = 64,
    parameter logic [NUM_MODES-1:0] BUZZER_EN = NUM_MODES'(1)
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic [NUM_MODES-1:0]           mode_req,
    input  logic [NUM_MODES*LED_WIDTH-1:0] src_leds,
    input  logic [NUM_MODES-1:0]           src_buzzer,
    output logic [NUM_MODES-1:0]           adc_switch,
    output logic [LED_WIDTH-1:0]           LEDs,
    output logic                           buzzer,
    output logic [NUM_MODES-1:0]           active_mode,
    output logic                           mode_valid
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    logic [NUM_MODES-1:0] sync_q1;
    logic [NUM_MODES-1:0] sync_q2;
    logic [NUM_MODES-1:0] db_q;
    logic [DB_W-1:0]      db_cnt_q [NUM_MODES];

    logic [NUM_MODES-1:0] tgt;
    logic                 tgt_new;
    logic [LED_WIDTH-1:0] led_sel;
    logic                 buz_sel;

    state_t               state_q;
    state_t               state_d;
    logic [NUM_MODES-1:0] mode_q;
    logic [NUM_MODES-1:0] mode_d;
    logic [SC_W-1:0]      sc_q;
    logic [SC_W-1:0]      sc_d;
    logic [LED_WIDTH-1:0] leds_q;
    logic [LED_WIDTH-1:0] leds_d;
    logic                 buz_q;
    logic                 buz_d;
    logic                 valid_q;
    logic                 valid_d;

    // Two-flop synchroniser for the raw switch inputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= mode_req;
            sync_q2 <= sync_q1;
        end
    end

    // Per-switch debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < int'(NUM_MODES); i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_MODES); i++) begin
                if (sync_q2[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= ~db_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Lowest-index debounced request wins; descending scan leaves the lowest one set.
    always_comb begin
        tgt = '0;
        for (int i = int'(NUM_MODES) - 1; i >= 0; i--) begin
            if (db_q[i]) begin
                tgt    = '0;
                tgt[i] = 1'b1;
            end
        end
    end

    assign tgt_new = (tgt != '0) && (tgt != mode_q);

    // Source mux driven by the committed one-hot mode.
    always_comb begin
        led_sel = '0;
        buz_sel = 1'b0;
        for (int i = 0; i < int'(NUM_MODES); i++) begin
            led_sel = led_sel | (src_leds[i*int'(LED_WIDTH) +: LED_WIDTH] & {LED_WIDTH{mode_q[i]}});
            buz_sel = buz_sel | (src_buzzer[i] & BUZZER_EN[i] & mode_q[i]);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= '0;
            sc_q    <= '0;
            leds_q  <= '0;
            buz_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sc_q    <= sc_d;
            leds_q  <= leds_d;
            buz_q   <= buz_d;
            valid_q <= valid_d;
        end
    end

    // Next state and next registered outputs; pins are blanked unless staying in ACTIVE.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sc_d    = sc_q;
        leds_d  = '0;
        buz_d   = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tgt != '0) begin
                    state_d = SWITCH;
                    mode_d  = tgt;
                    sc_d    = SC_LOAD;
                end
            end
            SWITCH: begin
                if (tgt_new) begin
                    mode_d = tgt;
                    sc_d   = SC_LOAD;
                end else if (sc_q == '0) begin
                    state_d = ACTIVE;
                    valid_d = 1'b1;
                end else begin
                    sc_d = sc_q - SC_W'(1);
                end
            end
            ACTIVE: begin
                if (tgt_new) begin
                    state_d = SWITCH;
                    mode_d  = tgt;
                    sc_d    = SC_LOAD;
                end else begin
                    valid_d = 1'b1;
                    leds_d  = led_sel;
                    buz_d   = buz_sel;
                end
            end
            default: begin
                state_d = IDLE;
                mode_d  = '0;
                sc_d    = '0;
            end
        endcase
    end

    assign adc_switch  = mode_q;
    assign active_mode = mode_q;
    assign LEDs        = leds_q;
    assign buzzer      = buz_q;
    assign mode_valid  = valid_q;

endmodule

// File: tb/tb_mode_arbiter.sv
// Directed bench for mode_arbiter with short debounce/settle parameters and hand-computed timing.
module tb_mode_arbiter;

    logic        CLOCK_50;
    logic        reset;
    logic [2:0]  mode_req;
    logic [23:0] src_leds;
    logic [2:0]  src_buzzer;
    logic [2:0]  adc_switch;
    logic [7:0]  LEDs;
    logic        buzzer;
    logic [2:0]  active_mode;
    logic        mode_valid;

    int passed = 0;
    int total  = 0;
    logic done = 1'b0;

    mode_arbiter #(
        .NUM_MODES      (3),
        .LED_WIDTH      (8),
        .DEBOUNCE_CYCLES(4),
        .SETTLE_CYCLES  (3),
        .BUZZER_EN      (3'b001)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .mode_req   (mode_req),
        .src_leds   (src_leds),
        .src_buzzer (src_buzzer),
        .adc_switch (adc_switch),
        .LEDs       (LEDs),
        .buzzer     (buzzer),
        .active_mode(active_mode),
        .mode_valid (mode_valid)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Select lines must mirror each other and never be multi-hot.
    always @(negedge CLOCK_50) begin
        if (!done) begin
            chk("inv_equal", 32'(adc_switch), 32'(active_mode));
            chk("inv_onehot0", 32'($onehot0(adc_switch)), 32'd1);
        end
    end

    initial begin
        reset      = 1'b1;
        mode_req   = 3'b010;
        src_leds   = {8'h3C, 8'hA5, 8'h5A};
        src_buzzer = 3'b000;

        // Reset with mode 1 already requested
        repeat (3) tick();
        chk("rst_adc", 32'(adc_switch), 32'd0);
        chk("rst_active", 32'(active_mode), 32'd0);
        chk("rst_leds", 32'(LEDs), 32'd0);
        chk("rst_buzzer", 32'(buzzer), 32'd0);
        chk("rst_valid", 32'(mode_valid), 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        chk("m1_adc_c6", 32'(adc_switch), 32'd0);
        tick();
        chk("m1_adc_c7", 32'(adc_switch), 32'b010);
        chk("m1_valid_c7", 32'(mode_valid), 32'd0);
        chk("m1_leds_c7", 32'(LEDs), 32'd0);
        tick();
        chk("m1_valid_c8", 32'(mode_valid), 32'd0);
        tick();
        chk("m1_valid_c9", 32'(mode_valid), 32'd0);
        tick();
        chk("m1_valid_c10", 32'(mode_valid), 32'd1);
        chk("m1_leds_c10", 32'(LEDs), 32'd0);
        tick();
        chk("m1_leds_c11", 32'(LEDs), 32'hA5);

        // Three-cycle glitch on switch 0 is rejected
        mode_req = 3'b011;
        repeat (3) tick();
        mode_req = 3'b010;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("glitch_adc", 32'(adc_switch), 32'b010);
            chk("glitch_valid", 32'(mode_valid), 32'd1);
            chk("glitch_leds", 32'(LEDs), 32'hA5);
        end

        // All three requested from IDLE: mode 0 wins
        reset    = 1'b1;
        mode_req = 3'b111;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("all_adc_c6", 32'(adc_switch), 32'd0);
        tick();
        chk("all_adc_c7", 32'(adc_switch), 32'b001);
        src_buzzer = 3'b111;
        repeat (3) tick();
        chk("all_valid", 32'(mode_valid), 32'd1);
        tick();
        chk("m0_buzzer", 32'(buzzer), 32'd1);
        chk("m0_leds", 32'(LEDs), 32'h5A);

        // Release switch 0: fall through to mode 1, whose buzzer is masked
        mode_req = 3'b110;
        repeat (6) tick();
        chk("rel0_adc_hold", 32'(adc_switch), 32'b001);
        chk("rel0_buzzer_hold", 32'(buzzer), 32'd1);
        tick();
        chk("rel0_adc", 32'(adc_switch), 32'b010);
        chk("rel0_buzzer_blank", 32'(buzzer), 32'd0);
        chk("rel0_valid_drop", 32'(mode_valid), 32'd0);
        chk("rel0_leds_blank", 32'(LEDs), 32'd0);
        repeat (2) tick();
        chk("rel0_valid_blank", 32'(mode_valid), 32'd0);
        tick();
        chk("rel0_valid", 32'(mode_valid), 32'd1);
        tick();
        chk("m1_buzzer_masked", 32'(buzzer), 32'd0);
        chk("m1_leds", 32'(LEDs), 32'hA5);

        // Switch to mode 2, then mode 0 wins debounce while settle counter is 1
        mode_req = 3'b100;
        repeat (2) tick();
        mode_req = 3'b101;
        repeat (4) tick();
        chk("sw2_adc_r6", 32'(adc_switch), 32'b010);
        tick();
        chk("sw2_adc_r7", 32'(adc_switch), 32'b100);
        chk("sw2_valid_r7", 32'(mode_valid), 32'd0);
        tick();
        chk("sw2_adc_r8", 32'(adc_switch), 32'b100);
        tick();
        chk("restart_adc", 32'(adc_switch), 32'b001);
        chk("restart_valid", 32'(mode_valid), 32'd0);
        tick();
        chk("restart_blank1", 32'(mode_valid), 32'd0);
        tick();
        chk("restart_blank2", 32'(mode_valid), 32'd0);
        tick();
        chk("restart_valid_up", 32'(mode_valid), 32'd1);
        tick();
        chk("restart_leds", 32'(LEDs), 32'h5A);
        chk("restart_buzzer", 32'(buzzer), 32'd1);

        // Enter mode 2, then release everything: mode is held and LEDs keep tracking
        mode_req = 3'b100;
        repeat (6) tick();
        chk("m2_adc_hold", 32'(adc_switch), 32'b001);
        tick();
        chk("m2_adc", 32'(adc_switch), 32'b100);
        repeat (3) tick();
        chk("m2_valid", 32'(mode_valid), 32'd1);
        tick();
        chk("m2_leds", 32'(LEDs), 32'h3C);
        chk("m2_buzzer_masked", 32'(buzzer), 32'd0);
        mode_req = 3'b000;
        repeat (10) tick();
        chk("none_adc", 32'(adc_switch), 32'b100);
        chk("none_valid", 32'(mode_valid), 32'd1);
        chk("none_leds", 32'(LEDs), 32'h3C);
        src_leds = {8'h77, 8'hA5, 8'h5A};
        chk("track_before_edge", 32'(LEDs), 32'h3C);
        tick();
        chk("track_77", 32'(LEDs), 32'h77);
        src_leds = {8'h81, 8'hA5, 8'h5A};
        tick();
        chk("track_81", 32'(LEDs), 32'h81);
        chk("track_valid", 32'(mode_valid), 32'd1);

        // Reset in the middle of the settle window, request held throughout
        mode_req = 3'b010;
        repeat (6) tick();
        chk("mid_adc_hold", 32'(adc_switch), 32'b100);
        tick();
        chk("mid_adc_switch", 32'(adc_switch), 32'b010);
        chk("mid_valid", 32'(mode_valid), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_adc", 32'(adc_switch), 32'd0);
        chk("mid_rst_active", 32'(active_mode), 32'd0);
        chk("mid_rst_leds", 32'(LEDs), 32'd0);
        chk("mid_rst_buzzer", 32'(buzzer), 32'd0);
        chk("mid_rst_valid", 32'(mode_valid), 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        chk("again_adc_c6", 32'(adc_switch), 32'd0);
        tick();
        chk("again_adc_c7", 32'(adc_switch), 32'b010);
        repeat (2) tick();
        chk("again_valid_c9", 32'(mode_valid), 32'd0);
        tick();
        chk("again_valid_c10", 32'(mode_valid), 32'd1);
        tick();
        chk("again_leds_c11", 32'(LEDs), 32'hA5);

        done = 1'b1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
